// File: rtl/char_row_reader.sv
// char_row_reader
//   Read-side sequencer for char_memory. On a start pulse it walks the glyph
//   cell array in raster order, drives the x/y read address, collects the
//   returned bits and presents one COLS-bit row at a time over valid/ready.
//
//   Optional feature macro: CHAR_ROW_READER_PARITY_EN
//     defined   -> row_parity is the registered XOR of row_data
//     undefined -> row_parity is tied to 0
//
// Ports
//   clock       rising-edge clock
//   rst         asynchronous active-high reset
//   start       begin a full-glyph read (sampled only in IDLE)
//   busy        high from the cycle after an accepted start through done
//   done        one-cycle pulse after the last row handshake
//   mem_write   write enable to char_memory, always 0
//   mem_x/mem_y read address to char_memory
//   mem_data    read bit from char_memory
//   row_data    assembled row, row_data[x] = cell (y, x)
//   row_index   y of the presented row
//   row_parity  XOR of row_data (see macro above)
//   row_valid   row available
//   row_ready   consumer accepts the row
module char_row_reader #(
    parameter int COLS         = 4,
    parameter int ROWS         = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_write,
    output logic [$clog2(COLS)-1:0]   mem_x,
    output logic [$clog2(ROWS)-1:0]   mem_y,
    input  logic                      mem_data,
    output logic [COLS-1:0]           row_data,
    output logic [$clog2(ROWS)-1:0]   row_index,
    output logic                      row_parity,
    output logic                      row_valid,
    input  logic                      row_ready
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic [COLS-1:0] row_q;
    logic [COLS-1:0] row_next;
    logic            cap_en;
    logic [XW-1:0]   cap_tag;
    logic            x_last;
    logic            y_last;

    assign x_last = (x_cnt == X_LAST);
    assign y_last = (y_cnt == Y_LAST);

    // State register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_ISSUE;
            S_ISSUE:   if (x_last) state_next = (READ_LATENCY == 1) ? S_WAIT : S_PRESENT;
            S_WAIT:    state_next = S_PRESENT;
            S_PRESENT: if (row_ready) state_next = y_last ? S_DONE : S_ISSUE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        row_valid = (state == S_PRESENT);
    end

    // Address counters double as the registered mem_x/mem_y outputs; they
    // saturate at the last column/row and clear on the way back to IDLE.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    x_cnt <= '0;
                    y_cnt <= '0;
                end
                S_ISSUE: begin
                    if (!x_last) x_cnt <= x_cnt + 1'b1;
                end
                S_PRESENT: begin
                    if (row_ready && !y_last) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Column tag travels alongside the read so that each returned bit lands
    // in the column it was addressed from.
    generate
        if (READ_LATENCY == 0) begin : g_lat0
            assign cap_en  = (state == S_ISSUE);
            assign cap_tag = x_cnt;
        end else begin : g_lat1
            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    cap_en  <= 1'b0;
                    cap_tag <= '0;
                end else begin
                    cap_en  <= (state == S_ISSUE);
                    cap_tag <= x_cnt;
                end
            end
        end
    endgenerate

    always_comb begin
        row_next = row_q;
        if (cap_en) row_next[cap_tag] = mem_data;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            row_q <= '0;
        end else begin
            row_q <= row_next;
        end
    end

`ifdef CHAR_ROW_READER_PARITY_EN
    // Parity is registered from the same next-row value, so it is always
    // coherent with row_data.
    logic parity_q;
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^row_next;
        end
    end
    assign row_parity = parity_q;
`else
    assign row_parity = 1'b0;
`endif

    assign row_data  = row_q;
    assign row_index = y_cnt;
    assign mem_x     = x_cnt;
    assign mem_y     = y_cnt;
    assign mem_write = 1'b0;

endmodule

// File: tb/tb_char_row_reader.sv
module tb_char_row_reader;

    localparam int COLS = 4;
    localparam int ROWS = 5;
    localparam int XW   = 2;
    localparam int YW   = 3;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic row_ready = 1'b0;

    logic            busy0, done0, wr0, md0, rp0, rv0;
    logic [XW-1:0]   mx0;
    logic [YW-1:0]   my0, ri0;
    logic [COLS-1:0] rd0;
    logic            busy1, done1, wr1, md1, rp1, rv1;
    logic [XW-1:0]   mx1;
    logic [YW-1:0]   my1, ri1;
    logic [COLS-1:0] rd1;

    logic [COLS-1:0] mem0 [ROWS];
    logic [COLS-1:0] mem1 [ROWS];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    char_row_reader #(.COLS(COLS), .ROWS(ROWS), .READ_LATENCY(1)) dut0 (
        .clock(clock), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .mem_write(wr0), .mem_x(mx0), .mem_y(my0), .mem_data(md0),
        .row_data(rd0), .row_index(ri0), .row_parity(rp0), .row_valid(rv0),
        .row_ready(row_ready)
    );

    char_row_reader #(.COLS(COLS), .ROWS(ROWS), .READ_LATENCY(0)) dut1 (
        .clock(clock), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .mem_write(wr1), .mem_x(mx1), .mem_y(my1), .mem_data(md1),
        .row_data(rd1), .row_index(ri1), .row_parity(rp1), .row_valid(rv1),
        .row_ready(row_ready)
    );

    // Behavioural char_memory: one-cycle synchronous read and combinational read
    always @(posedge clock) md0 <= mem0[int'(my0)][mx0];
    assign md1 = mem1[int'(my1)][mx1];

    // Observation mux selecting the DUT under test
    logic            sel = 1'b0;
    logic            o_busy, o_done, o_wr, o_par, o_valid;
    logic [XW-1:0]   o_x;
    logic [YW-1:0]   o_y, o_idx;
    logic [COLS-1:0] o_data;
    assign o_busy  = sel ? busy1 : busy0;
    assign o_done  = sel ? done1 : done0;
    assign o_wr    = sel ? wr1   : wr0;
    assign o_par   = sel ? rp1   : rp0;
    assign o_valid = sel ? rv1   : rv0;
    assign o_x     = sel ? mx1   : mx0;
    assign o_y     = sel ? my1   : my0;
    assign o_idx   = sel ? ri1   : ri0;
    assign o_data  = sel ? rd1   : rd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [COLS-1:0] exp_row(input int y);
        return sel ? mem1[y] : mem0[y];
    endfunction

    function automatic logic exp_par(input logic [COLS-1:0] r);
`ifdef CHAR_ROW_READER_PARITY_EN
        return ^r;
`else
        return 1'b0 & r[0];
`endif
    endfunction

    task automatic set_start(input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    task automatic load_plan();
        mem0[0] = 4'b0101; mem0[1] = 4'b1010; mem0[2] = 4'b1010;
        mem0[3] = 4'b0101; mem0[4] = 4'b1010;
        for (int i = 0; i < ROWS; i++) mem1[i] = mem0[i];
    endtask

    // One full glyph read. The model: rows come out in order 0..ROWS-1 with
    // the memory contents, each row takes COLS+latency+1 cycles when ready
    // is held high, and done follows the last handshake by one cycle.
    task automatic run_read(input logic s, input int ready_pct, input int stall_row,
                            input bit timing_chk, input bit extra_start);
        int cyc, hs, per, stall_left;
        bit finished, stalled, wr_seen, busy_bad;
        logic [COLS-1:0] pdata;
        logic [XW-1:0]   px;
        logic [YW-1:0]   py;
        sel = s;
        per = COLS + (s ? 0 : 1) + 1;
        cyc = 0; hs = 0; stall_left = 10;
        finished = 0; stalled = 0; wr_seen = 0; busy_bad = 0;
        @(negedge clock);
        set_start(1'b1);
        row_ready = ($urandom_range(99) < ready_pct);
        while (!finished && cyc < 400) begin
            @(negedge clock);
            cyc++;
            start0 = 1'b0;
            start1 = 1'b0;
            if (o_busy !== 1'b1) busy_bad = 1;
            if (o_wr !== 1'b0) wr_seen = 1;
            if (extra_start && cyc == 9) set_start(1'b1);
            if (stalled) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, pdata);
                check("hold_x", o_x, px);
                check("hold_y", o_y, py);
            end
            stalled = 0;
            if (o_valid && hs == stall_row && stall_left > 0) begin
                row_ready = 1'b0;
                stall_left--;
            end else begin
                row_ready = ($urandom_range(99) < ready_pct);
            end
            if (o_valid) begin
                if (row_ready) begin
                    if (hs >= ROWS) begin
                        check("extra_handshake", hs, ROWS - 1);
                    end else begin
                        check("row_index", o_idx, hs);
                        check("row_data", o_data, exp_row(hs));
                        check("row_parity", o_par, exp_par(exp_row(hs)));
                        if (timing_chk) check("valid_cycle", cyc, (hs + 1) * per);
                    end
                    hs++;
                end else begin
                    stalled = 1;
                    pdata = o_data; px = o_x; py = o_y;
                end
            end
            if (o_done) begin
                if (timing_chk) check("done_cycle", cyc, ROWS * per + 1);
                if (extra_start) set_start(1'b1);
                finished = 1;
            end
        end
        if (!finished) check("done_timeout", 0, 1);
        check("handshakes", hs, ROWS);
        check("busy_span", busy_bad, 0);
        @(negedge clock);
        start0 = 1'b0;
        start1 = 1'b0;
        check("busy_after", o_busy, 0);
        check("done_after", o_done, 0);
        check("addr_idle", {o_x, o_y}, 0);
        @(negedge clock);
        check("busy_idle", o_busy, 0);
        check("mem_write", wr_seen | o_wr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        load_plan();
        repeat (3) @(negedge clock);
        check("rst_dut0", {busy0, done0, wr0, mx0, my0, rd0, ri0, rp0, rv0}, 0);
        check("rst_dut1", {busy1, done1, wr1, mx1, my1, rd1, ri1, rp1, rv1}, 0);
        rst = 1'b0;

        // Basic read-out with ready held high
        run_read(1'b0, 100, -1, 1, 0);
        // Backpressure on row 2
        run_read(1'b0, 100, 2, 0, 0);
        // Start while busy and during done is ignored
        run_read(1'b0, 100, -1, 1, 1);

        // Reset during row 1 ISSUE
        sel = 1'b0;
        @(negedge clock);
        start0 = 1'b1;
        row_ready = 1'b1;
        repeat (8) begin
            @(negedge clock);
            start0 = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst_out", {busy0, done0, wr0, mx0, my0, rd0, ri0, rp0, rv0}, 0);
        repeat (2) begin
            @(negedge clock);
            check("midrst_done", done0, 0);
        end
        rst = 1'b0;
        run_read(1'b0, 100, -1, 1, 0);

        // Zero latency with a modified row 0
        mem1[0] = 4'b1100;
        run_read(1'b1, 100, -1, 1, 0);

        // Parity-sensitive row
        mem0[1] = 4'b1110;
        run_read(1'b0, 100, -1, 1, 0);

        // Random contents and random backpressure on both latencies
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < ROWS; i++) begin
                mem0[i] = 4'($urandom_range(15));
                mem1[i] = 4'($urandom_range(15));
            end
            if (k < 2) run_read(1'(k), 100, -1, 1, 0);
            else run_read(1'($urandom_range(1)), int'($urandom_range(90, 30)), -1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
